traffic_ctrl_fsm: RTL and testbench

//  Control stage that sits directly upstream of the traffic-light datapath.
//  - Sequences the north/east lamps through a fixed phase machine.
//  - Owns the interval timer that produces the datapath's L (long) and S (short) flags.
//  - Consumes the datapath status flags not_r, c_and_l, en_s and l_or_notc.
//  - Drives every s_*/en_* lamp strobe and the s_IC/en_IC counter-input select.

---
 rtl/traffic_pkg.sv | 63 ++++++
 rtl/interval_timer.sv | 56 +++++
 rtl/traffic_ctrl_fsm.sv | 122 ++++++++++++
 tb/tb_traffic_ctrl_fsm.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared encodings for the traffic-light control stage.
// Phase codes, counter-input selects and lamp patterns live here so the FSM
// and any datapath model agree on them. Build option: TRAFFIC_ALL_RED_EN adds
// the two all-red clearance phases to the encoding.
package traffic_pkg;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam logic [STATE_W-1:0] ST_INIT  = 3'd0;
  localparam logic [STATE_W-1:0] ST_N_GRN = 3'd1;
  localparam logic [STATE_W-1:0] ST_N_YEL = 3'd2;
  localparam logic [STATE_W-1:0] ST_E_GRN = 3'd3;
  localparam logic [STATE_W-1:0] ST_E_YEL = 3'd4;
`ifdef TRAFFIC_ALL_RED_EN
  localparam logic [STATE_W-1:0] ST_ALL_RED_N = 3'd5;
  localparam logic [STATE_W-1:0] ST_ALL_RED_E = 3'd6;
`endif

  // Counter-input select codes seen by the datapath.
  localparam logic [1:0] IC_SEL_ONE  = 2'b00;
  localparam logic [1:0] IC_SEL_R    = 2'b01;
  localparam logic [1:0] IC_SEL_NCL  = 2'b10;
  localparam logic [1:0] IC_SEL_NLNC = 2'b11;

  // One bit per lamp; field order matches the s_*/en_* port order.
  typedef struct packed {
    logic nr;
    logic ng;
    logic ny;
    logic er;
    logic eg;
    logic ey;
  } lamp_t;

  localparam lamp_t LAMP_RED_RED = 6'b100_100;
  localparam lamp_t LAMP_N_GRN   = 6'b010_100;
  localparam lamp_t LAMP_N_YEL   = 6'b001_100;
  localparam lamp_t LAMP_E_GRN   = 6'b100_010;
  localparam lamp_t LAMP_E_YEL   = 6'b100_001;

  // Lamp pattern shown while in a given phase; unknown codes fail safe to red.
  function automatic lamp_t lamp_of(input state_t s);
    case (s)
      ST_N_GRN: lamp_of = LAMP_N_GRN;
      ST_N_YEL: lamp_of = LAMP_N_YEL;
      ST_E_GRN: lamp_of = LAMP_E_GRN;
      ST_E_YEL: lamp_of = LAMP_E_YEL;
      default:  lamp_of = LAMP_RED_RED;
    endcase
  endfunction

  // Counter-input select for a phase; yellow and all-red use the constant-one input.
  function automatic logic [1:0] ic_sel_of(input state_t s);
    case (s)
      ST_INIT:  ic_sel_of = IC_SEL_R;
      ST_N_GRN: ic_sel_of = IC_SEL_NCL;
      ST_E_GRN: ic_sel_of = IC_SEL_NLNC;
      default:  ic_sel_of = IC_SEL_ONE;
    endcase
  endfunction

endpackage

// File: rtl/interval_timer.sv
// interval_timer: per-phase interval counter producing the short (S) and
// long (L) flags. Counts from 0 in the first cycle of a phase, saturates at
// LONG_CYCLES-1, and both flags drop in the same cycle the count restarts.
module interval_timer
  import traffic_pkg::*;
#(
  parameter int SHORT_CYCLES = 4,
  parameter int LONG_CYCLES  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tmr_S,
  output logic tmr_L
);

  localparam int CNT_W = $clog2(LONG_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SHORT = CNT_W'(SHORT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmr_s_q, tmr_s_d;
  logic             tmr_l_q, tmr_l_d;

  // Next count and flag values; flags are derived from the next count so they
  // line up with the count the phase will see in the following cycle.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tmr_s_d = (cnt_d >= CNT_SHORT);
    tmr_l_d = (cnt_d >= CNT_MAX);
  end

  // Count and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      cnt_q   <= '0;
      tmr_s_q <= 1'b0;
      tmr_l_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tmr_s_q <= tmr_s_d;
      tmr_l_q <= tmr_l_d;
    end
  end

  assign tmr_S = tmr_s_q;
  assign tmr_L = tmr_l_q;

endmodule

// File: rtl/traffic_ctrl_fsm.sv
// traffic_ctrl_fsm: phase sequencer for the north/east traffic-light datapath.
// Walks INIT -> N_GRN -> N_YEL -> E_GRN -> E_YEL -> N_GRN, owns the interval
// timer, and issues a one-cycle lamp/load strobe on the first cycle of every
// phase. A red-hold request (not_r=0) returns to INIT from anywhere.
// Build option: TRAFFIC_ALL_RED_EN inserts ALL_RED_N / ALL_RED_E clearance
// phases after each yellow.
module traffic_ctrl_fsm
  import traffic_pkg::*;
#(
  parameter int SHORT_CYCLES = 4,
  parameter int LONG_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       not_r,
  input  logic       c_and_l,
  input  logic       en_s,
  input  logic       l_or_notc,
  output logic       tmr_L,
  output logic       tmr_S,
  output logic       s_NR,
  output logic       s_NG,
  output logic       s_NY,
  output logic       s_ER,
  output logic       s_EG,
  output logic       s_EY,
  output logic       en_NR,
  output logic       en_NG,
  output logic       en_NY,
  output logic       en_ER,
  output logic       en_EG,
  output logic       en_EY,
  output logic [1:0] s_IC,
  output logic       en_IC
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               fresh_q;   // high through reset: first cycle out of reset is a phase entry
  logic               entry;     // the coming edge starts a new phase
  logic               restart;   // the coming edge zeroes the interval timer
  lamp_t              lamp_s_q;
  logic               lamp_en_q;
  logic [1:0]         s_ic_q;
  logic               en_ic_q;

  // Next phase; leaving reset and red-hold both force INIT ahead of any phase condition.
  always_comb begin
    state_d = state_q;
    if (fresh_q || !not_r) begin
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_INIT:      if (en_s)      state_d = ST_N_GRN;
        ST_N_GRN:     if (c_and_l)   state_d = ST_N_YEL;
        ST_E_GRN:     if (l_or_notc) state_d = ST_E_YEL;
`ifdef TRAFFIC_ALL_RED_EN
        ST_N_YEL:     if (en_s)      state_d = ST_ALL_RED_N;
        ST_ALL_RED_N: if (en_s)      state_d = ST_E_GRN;
        ST_E_YEL:     if (en_s)      state_d = ST_ALL_RED_E;
        ST_ALL_RED_E: if (en_s)      state_d = ST_N_GRN;
`else
        ST_N_YEL:     if (en_s)      state_d = ST_E_GRN;
        ST_E_YEL:     if (en_s)      state_d = ST_N_GRN;
`endif
        default:                     state_d = ST_INIT;
      endcase
    end
  end

  // Holding INIT under red-hold is not a new phase, but the timer still stays at zero.
  assign entry   = fresh_q || (state_d != state_q);
  assign restart = entry || !not_r;

  interval_timer #(
    .SHORT_CYCLES (SHORT_CYCLES),
    .LONG_CYCLES  (LONG_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tmr_S   (tmr_S),
    .tmr_L   (tmr_L)
  );

  // Phase register plus registered strobes, so lamp values and load enables
  // change together with the phase they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      fresh_q   <= 1'b1;
      lamp_s_q  <= '0;
      lamp_en_q <= 1'b0;
      s_ic_q    <= IC_SEL_ONE;
      en_ic_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fresh_q   <= 1'b0;
      lamp_s_q  <= lamp_of(state_d);
      lamp_en_q <= entry;
      s_ic_q    <= ic_sel_of(state_d);
      en_ic_q   <= 1'b1;
    end
  end

  assign s_NR  = lamp_s_q.nr;
  assign s_NG  = lamp_s_q.ng;
  assign s_NY  = lamp_s_q.ny;
  assign s_ER  = lamp_s_q.er;
  assign s_EG  = lamp_s_q.eg;
  assign s_EY  = lamp_s_q.ey;

  assign en_NR = lamp_en_q;
  assign en_NG = lamp_en_q;
  assign en_NY = lamp_en_q;
  assign en_ER = lamp_en_q;
  assign en_EG = lamp_en_q;
  assign en_EY = lamp_en_q;

  assign s_IC  = s_ic_q;
  assign en_IC = en_ic_q;

endmodule

// File: tb/tb_traffic_ctrl_fsm.sv
// tb_traffic_ctrl_fsm: scoreboard bench for traffic_ctrl_fsm (SHORT=4, LONG=16).
// The stimulus process walks a directed phase sequence and pushes the expected
// lamp pattern, counter select and gap (edges since the previous strobe or
// since reset release) for every phase entry. The monitor pops one entry per
// observed strobe. Datapath flags are modelled from tmr_* plus bench C and R.
module tb_traffic_ctrl_fsm;

  typedef struct {
    logic [5:0] lamps;   // {NR,NG,NY,ER,EG,EY}
    logic [1:0] ic;
    int         gap;
  } exp_t;

  localparam logic [5:0] L_RED_RED = 6'b100_100;
  localparam logic [5:0] L_N_GRN   = 6'b010_100;
  localparam logic [5:0] L_N_YEL   = 6'b001_100;
  localparam logic [5:0] L_E_GRN   = 6'b100_010;
  localparam logic [5:0] L_E_YEL   = 6'b100_001;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic car_c = 1'b1;   // C: east car waiting
  logic red_r = 1'b0;   // R: all-red hold request

  logic       not_r, c_and_l, en_s, l_or_notc;
  logic       tmr_L, tmr_S;
  logic       s_NR, s_NG, s_NY, s_ER, s_EG, s_EY;
  logic       en_NR, en_NG, en_NY, en_ER, en_EG, en_EY;
  logic [1:0] s_IC;
  logic       en_IC;
  logic [5:0] s_vec, en_vec;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   edges   = 0;
  int   last_edge = 0;
  exp_t exp_q[$];

  assign not_r     = ~red_r;
  assign en_s      = tmr_S;
  assign c_and_l   = car_c & tmr_L;
  assign l_or_notc = tmr_L | ~car_c;
  assign s_vec     = {s_NR, s_NG, s_NY, s_ER, s_EG, s_EY};
  assign en_vec    = {en_NR, en_NG, en_NY, en_ER, en_EG, en_EY};

  traffic_ctrl_fsm #(
    .SHORT_CYCLES (4),
    .LONG_CYCLES  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .not_r     (not_r),
    .c_and_l   (c_and_l),
    .en_s      (en_s),
    .l_or_notc (l_or_notc),
    .tmr_L     (tmr_L),
    .tmr_S     (tmr_S),
    .s_NR      (s_NR),
    .s_NG      (s_NG),
    .s_NY      (s_NY),
    .s_ER      (s_ER),
    .s_EG      (s_EG),
    .s_EY      (s_EY),
    .en_NR     (en_NR),
    .en_NG     (en_NG),
    .en_NY     (en_NY),
    .en_ER     (en_ER),
    .en_EG     (en_EG),
    .en_EY     (en_EY),
    .s_IC      (s_IC),
    .en_IC     (en_IC)
  );

  always #5 clk = ~clk;

  // Edges since reset was last sampled high.
  always @(posedge clk) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input logic [5:0] lamps, input logic [1:0] ic, input int gap);
    exp_t e;
    e.lamps = lamps;
    e.ic    = ic;
    e.gap   = gap;
    exp_q.push_back(e);
  endtask

  // Clearance phase that exists only in the all-red build (exits on S: 4 edges).
  task automatic all_red_phase();
`ifdef TRAFFIC_ALL_RED_EN
    expect_entry(L_RED_RED, 2'b00, 4);
    tick(4);
`endif
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_s_lamps"}, s_vec, 6'b0);
    check({tag, "_en_lamps"}, en_vec, 6'b0);
    check({tag, "_s_IC"}, s_IC, 2'b00);
    check({tag, "_en_IC"}, en_IC, 1'b0);
    check({tag, "_tmr_S"}, tmr_S, 1'b0);
    check({tag, "_tmr_L"}, tmr_L, 1'b0);
  endtask

  // Monitor: every strobe consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_edge = 0;
    end else if (en_vec != 6'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", en_vec, 6'b0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_all_en", en_vec, 6'b111111);
        check("pulse_lamps", s_vec, e.lamps);
        check("pulse_s_IC", s_IC, e.ic);
        check("pulse_gap", edges - last_edge, e.gap);
        check("pulse_tmr_S", tmr_S, 1'b0);
        check("pulse_tmr_L", tmr_L, 1'b0);
      end
      last_edge = edges;
    end
  end

  // Watchdog.
  initial begin
    repeat (3000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, %0d entries pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    tick(3);
    check_idle("reset");
    rst = 1'b0;

    expect_entry(L_RED_RED, 2'b01, 1);   tick(1);
    check("run_en_IC", en_IC, 1'b1);
    expect_entry(L_N_GRN, 2'b10, 4);     tick(4);
    expect_entry(L_N_YEL, 2'b00, 16);    tick(16);   // C=1: waits for L
    all_red_phase();
    expect_entry(L_E_GRN, 2'b11, 4);     tick(4);
    expect_entry(L_E_YEL, 2'b00, 16);    tick(16);   // C=1: waits for L
    all_red_phase();
    expect_entry(L_N_GRN, 2'b10, 4);     tick(4);
    expect_entry(L_N_YEL, 2'b00, 16);    tick(16);
    car_c = 1'b0;
    all_red_phase();
    expect_entry(L_E_GRN, 2'b11, 4);     tick(4);
    expect_entry(L_E_YEL, 2'b00, 1);     tick(1);    // C=0: leaves on first evaluation
    all_red_phase();
    expect_entry(L_N_GRN, 2'b10, 4);     tick(4);

    // N_GRN with no east car holds; L saturates and stays set.
    tick(20);
    check("ngrn_hold_tmr_L", tmr_L, 1'b1);
    check("ngrn_hold_tmr_S", tmr_S, 1'b1);
    car_c = 1'b1;
    expect_entry(L_N_YEL, 2'b00, 21);    tick(1);

    // Red hold one edge into N_YEL.
    tick(1);
    red_r = 1'b1;
    expect_entry(L_RED_RED, 2'b01, 2);   tick(1);
    check("rhold_timer_zero", dut.u_timer.cnt_q, 0);
    tick(3);                                          // INIT re-entries: no strobe
    check("rhold_tmr_S_held", tmr_S, 1'b0);
    check("rhold_s_IC", s_IC, 2'b01);
    red_r = 1'b0;
    expect_entry(L_N_GRN, 2'b10, 7);     tick(7);
    expect_entry(L_N_YEL, 2'b00, 16);    tick(16);
    all_red_phase();
    expect_entry(L_E_GRN, 2'b11, 4);     tick(4);

    // Reset held three edges mid E_GRN.
    tick(3);
    rst = 1'b1;
    tick(1); check_idle("midrst1");
    tick(1); check_idle("midrst2");
    tick(1); check_idle("midrst3");
    rst = 1'b0;
    expect_entry(L_RED_RED, 2'b01, 1);   tick(1);
    expect_entry(L_N_GRN, 2'b10, 4);     tick(4);
    tick(2);

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
